// File: rtl/alu_pkg.sv
// Shared encodings and constants for the 8-bit ALU sequencer.
package alu_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned RW       = 16;
  localparam int unsigned MUL_ITER = 8;
  localparam int unsigned CNT_W    = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DN   = 2'd3;

endpackage

// File: rtl/seq_adder8.sv
// Shared 8-bit adder with carry-in and carry-out.
module seq_adder8
  import alu_pkg::*;
(
  input  logic [DW-1:0] IA,
  input  logic [DW-1:0] IB,
  input  logic          cin,
  output logic [DW-1:0] IS,
  output logic          cout
);

  assign {cout, IS} = {1'b0, IA} + {1'b0, IB} + {(DW)'(0), cin};

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ADD/SUB/MUL sequencer around one shared 8-bit adder.
// MUL is a right-shifting shift-add over MUL_ITER iterations.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [1:0]    OP,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          BUSY,
  output logic          DONE,
  output logic [RW-1:0] RES,
  output logic          V,
  output logic          C,
  output logic          ERR
);

  logic [1:0]       r_state, w_state_nxt;
  logic [DW-1:0]    r_a, w_a_nxt;
  logic [DW-1:0]    r_b, w_b_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [RW-1:0]    r_p, w_p_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0]    r_res, w_res_nxt;
  logic             r_v, w_v_nxt;
  logic             r_c, w_c_nxt;
  logic             r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [DW-1:0]    w_add_a, w_add_b, w_sum;
  logic             w_add_cin, w_cout;
  logic             w_mul_c;
  logic [DW-1:0]    w_mul_s;
  logic [RW-1:0]    w_mul_p;

  // Adder operand mux: MUL accumulates A into P's upper byte, SUB uses A + ~B + 1
  always_comb begin
    w_add_a   = r_a;
    w_add_b   = r_b;
    w_add_cin = 1'b0;
    if (r_state == S_MUL) begin
      w_add_a = r_p[RW-1:DW];
      w_add_b = r_a;
    end else if (r_op == OP_SUB) begin
      w_add_b   = ~r_b;
      w_add_cin = 1'b1;
    end
  end

  seq_adder8 u_adder (
    .IA   (w_add_a),
    .IB   (w_add_b),
    .cin  (w_add_cin),
    .IS   (w_sum),
    .cout (w_cout)
  );

  assign w_mul_c = r_p[0] ? w_cout : 1'b0;
  assign w_mul_s = r_p[0] ? w_sum  : r_p[RW-1:DW];
  assign w_mul_p = {w_mul_c, w_mul_s, r_p[DW-1:1]};

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_p_nxt     = r_p;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_v_nxt     = r_v;
    w_c_nxt     = r_c;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_a_nxt   = A;
          w_b_nxt   = B;
          w_op_nxt  = OP;
          w_err_nxt = 1'b0;
          if (OP == OP_MUL) begin
            w_state_nxt = S_MUL;
            w_p_nxt     = {(DW)'(0), B};
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_DN;
        w_done_nxt  = 1'b1;
        case (r_op)
          OP_ADD, OP_SUB: begin
            w_res_nxt = {(DW)'(0), w_sum};
            w_c_nxt   = w_cout;
            w_v_nxt   = (r_a[DW-1] == w_add_b[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);
            w_err_nxt = 1'b0;
          end
          default: begin
            w_res_nxt = '0;
            w_c_nxt   = 1'b0;
            w_v_nxt   = 1'b0;
            w_err_nxt = (r_op == OP_ILL);
          end
        endcase
      end
      S_MUL: begin
        w_p_nxt   = w_mul_p;
        w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        if (r_cnt == CNT_W'(MUL_ITER - 1)) begin
          w_state_nxt = S_DN;
          w_done_nxt  = 1'b1;
          w_res_nxt   = w_mul_p;
          w_v_nxt     = 1'b0;
          w_c_nxt     = |w_mul_p[RW-1:DW];
        end
      end
      S_DN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_p     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_v     <= 1'b0;
      r_c     <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_p     <= w_p_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_v     <= w_v_nxt;
      r_c     <= w_c_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign RES  = r_res;
  assign V    = r_v;
  assign C    = r_c;
  assign ERR  = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: latency-based reference model plus directed literals.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [1:0]  OP;
  logic [7:0]  A, B;
  logic        BUSY, DONE, V, C, ERR;
  logic [15:0] RES;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  alu_sequencer dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .RES   (RES),
    .V     (V),
    .C     (C),
    .ERR   (ERR)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for one command
  task automatic golden(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] r, output logic v, output logic c, output logic e);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; v = 1'b0; c = 1'b0; e = 1'b0;
    case (op)
      2'b00: begin
        r = {8'h00, 8'(a + b)};
        c = (int'(a) + int'(b)) > 255;
        s = sa + sb;
        v = (s > 127) || (s < -128);
      end
      2'b01: begin
        r = {8'h00, 8'(a - b)};
        c = (a >= b);
        s = sa - sb;
        v = (s > 127) || (s < -128);
      end
      2'b10: begin
        r = 16'(a) * 16'(b);
        c = (r > 16'd255);
      end
      default: e = 1'b1;
    endcase
  endtask

  // Reference model: tracks edges until DONE rather than any state encoding
  logic        m_busy = 0, m_done = 0, m_v = 0, m_c = 0, m_err = 0;
  logic [15:0] m_res = 0;
  logic [15:0] p_res;
  logic        p_v, p_c, p_e;
  int          m_left = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_done = 0; m_res = 0; m_v = 0; m_c = 0; m_err = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_res = p_res; m_v = p_v; m_c = p_c; m_err = p_e;
      end
    end else if (START) begin
      golden(OP, A, B, p_res, p_v, p_c, p_e);
      m_err  = 0;
      m_busy = 1;
      m_left = (OP == 2'b10) ? 8 : 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", 16'(BUSY), 16'(m_busy));
      check("done", 16'(DONE), 16'(m_done));
      check("res",  RES,       m_res);
      check("v",    16'(V),    16'(m_v));
      check("c",    16'(C),    16'(m_c));
      check("err",  16'(ERR),  16'(m_err));
    end
  end

  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] er, input logic ev, input logic ec, input logic ee, input int lat);
    int n;
    bit got;
    got = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1; OP = op; A = a; B = b;
    for (n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      START = 1'b0; OP = 2'($urandom); A = 8'($urandom); B = 8'($urandom);
      @(negedge CLK);
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    check({nm, "_lat"}, got ? 16'(n) : 16'hFFFF, 16'(lat));
    check({nm, "_res"}, RES, er);
    check({nm, "_v"},   16'(V),   16'(ev));
    check({nm, "_c"},   16'(C),   16'(ec));
    check({nm, "_err"}, 16'(ERR), 16'(ee));
  endtask

  task automatic count_done(input string nm, input int cycles);
    int d;
    d = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (DONE) d++;
    end
    check(nm, 16'(d), 16'd0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; OP = 2'b00; A = 8'h00; B = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 16'(BUSY), 16'd0);
    check("rst_done", 16'(DONE), 16'd0);
    check("rst_res",  RES,       16'h0000);
    check("rst_err",  16'(ERR),  16'd0);
    RST = 1'b0;
    chk_en = 1'b1;

    run_cmd("add7f",  2'b00, 8'h7F, 8'h01, 16'h0080, 1'b1, 1'b0, 1'b0, 2);
    run_cmd("addff",  2'b00, 8'hFF, 8'h01, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
    run_cmd("sub",    2'b01, 8'h05, 8'h07, 16'h00FE, 1'b0, 1'b0, 1'b0, 2);
    run_cmd("mul0f",  2'b10, 8'h0F, 8'h11, 16'h00FF, 1'b0, 1'b0, 1'b0, 9);
    run_cmd("mulff",  2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, 1'b0, 9);
    run_cmd("ill",    2'b11, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
    run_cmd("addclr", 2'b00, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0, 1'b0, 2);

    // START pulses at MUL cycle 3 and in DN must be ignored
    @(posedge CLK); #1;
    START = 1'b1; OP = 2'b10; A = 8'h12; B = 8'h34;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b1; OP = 2'b00; A = 8'h55; B = 8'h66;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("ign_done", 16'(DONE), 16'd1);
    check("ign_res",  RES,       16'h03A8);
    check("ign_c",    16'(C),    16'd1);
    START = 1'b1; OP = 2'b01; A = 8'h09; B = 8'h01;
    @(posedge CLK); #1;
    START = 1'b0;
    count_done("ign_nodup", 12);
    check("ign_hold", RES, 16'h03A8);

    // Reset mid-multiply aborts without DONE
    @(posedge CLK); #1;
    START = 1'b1; OP = 2'b10; A = 8'hFF; B = 8'hFF;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("ab_busy", 16'(BUSY), 16'd0);
    check("ab_done", 16'(DONE), 16'd0);
    check("ab_res",  RES,       16'h0000);
    check("ab_vce",  {13'd0, V, C, ERR}, 16'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    count_done("ab_nodone", 12);
    run_cmd("add34", 2'b00, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0, 1'b0, 2);

    // Randomized traffic, including START noise while busy and rare resets
    for (int i = 0; i < 2000; i++) begin
      @(posedge CLK); #1;
      RST   = ($urandom_range(0, 299) == 0);
      START = ($urandom_range(0, 2) == 0);
      OP    = 2'($urandom);
      A     = 8'($urandom);
      B     = 8'($urandom);
    end
    @(posedge CLK); #1;
    RST = 1'b0; START = 1'b0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
